uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one `uart_tx` serializer among `NUM_REQ` byte producers using round-robin arbitration. Accepts a byte from the winning requester with a valid/ready handshake and issues a one-cycle `data_valid` pulse to the transmitter. It then holds off further grants until the transmitter's `tx_done` rising edge plus a programmable inter-frame gap. The block sits between the byte sources (command responder, debug/status formatter, loopback path) and the single `uart_tx` instance driving the pin.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 32: must match the `uart_tx` instance; used only to size the timeout.
- `GAP_CYCLES`, 2: idle cycles after `tx_done` before the next grant, 1..255.
- `TIMEOUT_CYCLES`, 12*CLKS_PER_BIT: abort limit in WAIT_DONE.

Ports:
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  8*NUM_REQ  byte i at `[8*i+7:8*i]`.
- `req_ready`  out  NUM_REQ  one-cycle accept strobe, at most one bit high.
- `tx_data_valid`  out  1  to `uart_tx` `data_valid`; one-cycle pulse.
- `tx_data`  out  8  to `uart_tx` `data_in`; registered and stable from pulse to done.
- `tx_done`  in  1  from `uart_tx`; high for 2 cycles per frame.
- `busy`  out  1  high whenever the state is not ARB.
- `grant_id`  out  clog2(NUM_REQ)  requester currently or last served.
- `timeout_err`  out  1  one-cycle pulse on abort.

## Operation
- States: ARB, CAPTURE, SEND, WAIT_DONE, GAP.
- **ARB:**
  - If any `req_valid` is high, select the first set bit searching from `last+1` modulo NUM_REQ.
  - Register it into `grant_id` and go to CAPTURE.
  - Otherwise stay in ARB.
- **CAPTURE:**
  - `req_ready[grant_id] = req_valid[grant_id]`.
  - If the valid is high: register `req_data[grant_id]` into `tx_data`, set `last = grant_id`, go to SEND.
  - If the valid has dropped: no ready, `last` unchanged, return to ARB.
- **SEND:** `tx_data_valid` = 1 for exactly this cycle; go to WAIT_DONE.
- **WAIT_DONE:** wait for the `tx_done` rising edge (`tx_done & ~tx_done_q`), then load the gap counter and go to GAP.
- **GAP:** count `GAP_CYCLES` down to 0, then go to ARB. This guarantees `uart_tx` has returned to idle before the next pulse.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready` is seen.
- A level `tx_done` carried over from the previous frame is never counted twice, because only the edge is used.
- `tx_done` outside WAIT_DONE is ignored; `tx_done_q` still tracks it.

## Timing
- Reset values (asynchronous, `i_rst_n` = 0):
  - State ARB.
  - `last` = NUM_REQ-1, so requester 0 wins first.
  - `req_ready`, `tx_data_valid`, `busy`, `timeout_err`, `tx_data`, `grant_id`, `tx_done_q` all 0.
- Latency:
  - `req_valid` high in ARB at cycle t gives `req_ready` at t+1 and `tx_data_valid` at t+2.
  - From `tx_done` rising at cycle d, the next ARB evaluation occurs at d+1+GAP_CYCLES.
- All outputs are registered or decoded from the state register only; there are no combinational input-to-output paths except `req_ready`'s dependence on `req_valid`.
- Reset mid-frame: the arbiter returns to ARB immediately. `uart_tx` has no reset, so the system resets both or tolerates one partial frame.
- Simultaneous requests: strict rotation. With all NUM_REQ requesters valid, each is granted once per NUM_REQ frames.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A WAIT_DONE cycle counter of width clog2(TIMEOUT_CYCLES+1) clears on entry.
  - On reaching TIMEOUT_CYCLES without a done edge: pulse `timeout_err` for one cycle, go to GAP.
- Undefined: no counter; `timeout_err` is tied 0; WAIT_DONE waits indefinitely.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants: ARB=3'd0, CAPTURE=3'd1, SEND=3'd2, WAIT_DONE=3'd3, GAP=3'd4.
  - Default `CLKS_PER_BIT`.
- Sub-module `rr_arbiter`: combinational round-robin priority select.
  - Inputs: `req`, `last`.
  - Outputs: `gnt_id`, `any`.
- The FSM, capture register and counters live in the top module.

## Test plan
- Single requester: req 2 valid with 0xA5 -> `req_ready[2]` one cycle later, `tx_data_valid` pulse with `tx_data`=0xA5, serial line carries 0xA5 LSB-first, `busy` falls GAP_CYCLES+1 after the `tx_done` edge.
- All four valid continuously with bytes 0x10..0x13 -> grant order 0,1,2,3,0; never two grants to the same requester while others wait.
- Requester 1 drops `req_valid` during CAPTURE -> no `req_ready`, no `tx_data_valid`, back to ARB, next grant goes to requester 1 again if it reasserts.
- `tx_done` held high for 2 cycles, then req 3 valid immediately -> exactly one frame per done, second pulse occurs no earlier than GAP_CYCLES after the edge.
- With `UART_TX_ARB_TIMEOUT_EN`, stub `tx_done` stuck at 0 -> `timeout_err` pulses at WAIT_DONE entry + TIMEOUT_CYCLES, then ARB resumes.
- `i_rst_n` asserted in WAIT_DONE -> all outputs 0 asynchronously, first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and UART defaults for the tx arbiter slice
package uart_pkg;
  typedef enum logic [2:0] {
    ARB       = 3'd0,
    CAPTURE   = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_e;
  localparam int UART_CLKS_PER_BIT = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select, first set req after last (mod N)
//   req    in  N       request vector
//   last   in  clog2N  previously served index
//   gnt_id out clog2N  selected index (valid when any)
//   any    out 1       at least one request
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] idx;
  // Walk the rotation backwards so the closest candidate after last wins.
  always_comb begin
    gnt_id = last;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) gnt_id = idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers
//   i_clk, i_rst_n        clock, async active-low reset
//   req_valid/req_data    per-requester byte offer (byte i at [8*i+7:8*i])
//   req_ready             one-cycle accept strobe, one-hot
//   tx_data_valid/tx_data pulse and held byte to uart_tx
//   tx_done               frame-complete level from uart_tx (edge used)
//   busy, grant_id        status; timeout_err one-cycle abort pulse
//   Optional: define UART_TX_ARB_TIMEOUT_EN to abort a stuck WAIT_DONE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CLKS_PER_BIT   = UART_CLKS_PER_BIT,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 12 * CLKS_PER_BIT
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_data_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      CLKS_PER_BIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end
  arb_state_e    state_q;
  logic [IW-1:0] last_q, grant_q, gnt;
  logic [7:0]    tx_data_q, gap_q;
  logic          tx_done_q, any, done_edge;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (req_valid),
    .last   (last_q),
    .gnt_id (gnt),
    .any    (any)
  );
  // Only the rising edge counts, so a done level spanning frames is seen once.
  assign done_edge     = tx_done & ~tx_done_q;
  assign req_ready     = (state_q == CAPTURE) ? (req_valid & (NUM_REQ'(1) << grant_q)) : '0;
  assign tx_data_valid = state_q == SEND;
  assign busy          = state_q != ARB;
  assign tx_data       = tx_data_q;
  assign grant_id      = grant_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          terr_q;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB;
      last_q    <= IW'(NUM_REQ - 1);
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_done_q <= 1'b0;
      gap_q     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_q     <= '0;
      terr_q    <= 1'b0;
`endif
    end else begin
      tx_done_q <= tx_done;
`ifdef UART_TX_ARB_TIMEOUT_EN
      terr_q    <= 1'b0;
`endif
      case (state_q)
        ARB: if (any) begin
          grant_q <= gnt;
          state_q <= CAPTURE;
        end
        CAPTURE: if (req_valid[grant_q]) begin
          tx_data_q <= req_data[8*grant_q +: 8];
          last_q    <= grant_q;
          state_q   <= SEND;
        end else state_q <= ARB;
        SEND: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_edge) begin
            gap_q   <= GAP_LOAD;
            state_q <= GAP;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            terr_q  <= 1'b1;
            gap_q   <= GAP_LOAD;
            state_q <= GAP;
          end else tmo_q <= tmo_q + 1'b1;
`endif
        end
        GAP: if (gap_q == '0) state_q <= ARB; else gap_q <= gap_q - 1'b1;
        default: state_q <= ARB;
      endcase
    end
  end
endmodule
